// File: rtl/svm_sched_pkg.sv
// Shared scheduler types: owner-ID width, default dependency bitmap width and the
// scheduled-transaction record passed between scheduler, arbiter and executor.
package svm_sched_pkg;

  localparam int OWNER_ID_W           = 64;
  localparam int MAX_DEPENDENCIES_DEF = 256;

  typedef struct packed {
    logic [OWNER_ID_W-1:0]           owner_id;
    logic [MAX_DEPENDENCIES_DEF-1:0] read_deps;
    logic [MAX_DEPENDENCIES_DEF-1:0] write_deps;
  } sched_txn_t;

endpackage

// File: rtl/batch_output_arbiter_rr_arbiter.sv
// Work-conserving round-robin arbiter. The search starts one past the last accepted
// grant; last_grant moves only when the granted request is actually taken.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          enable,
  input  logic          accept,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic [IW-1:0] last_grant;
  logic [IW-1:0] cand;
  logic          found;

  // N is a power of two, so IW-bit addition wraps modulo N for free.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    grant     = '0;
    cand      = '0;
    for (int i = 0; i < N; i++) begin
      cand = last_grant + IW'(i) + IW'(1);
      if (!found && req[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
    if (enable && found) grant[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= IW'(N - 1);
    end else if (accept) begin
      last_grant <= grant_idx;
    end
  end

endmodule

// File: rtl/batch_output_arbiter.sv
// Merges per-instance scheduled-transaction streams into one registered, source-tagged
// stream. Optional statistics counters are built only when ARB_STATS_EN is defined.
module batch_output_arbiter
  import svm_sched_pkg::*;
#(
  parameter int NUM_PARALLEL_INSTANCES = 4,
  parameter int MAX_DEPENDENCIES       = MAX_DEPENDENCIES_DEF,
  parameter int SRC_W                  = $clog2(NUM_PARALLEL_INSTANCES)
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic [NUM_PARALLEL_INSTANCES-1:0]                s_axis_tvalid,
  output logic [NUM_PARALLEL_INSTANCES-1:0]                s_axis_tready,
  input  logic [NUM_PARALLEL_INSTANCES*OWNER_ID_W-1:0]     s_axis_tdata_owner_programID,
  input  logic [NUM_PARALLEL_INSTANCES*MAX_DEPENDENCIES-1:0] s_axis_tdata_read_dependencies,
  input  logic [NUM_PARALLEL_INSTANCES*MAX_DEPENDENCIES-1:0] s_axis_tdata_write_dependencies,
  output logic                                             m_axis_tvalid,
  input  logic                                             m_axis_tready,
  output logic [OWNER_ID_W-1:0]                            m_axis_tdata_owner_programID,
  output logic [MAX_DEPENDENCIES-1:0]                      m_axis_tdata_read_dependencies,
  output logic [MAX_DEPENDENCIES-1:0]                      m_axis_tdata_write_dependencies,
  output logic [SRC_W-1:0]                                 m_axis_tdest,
  output logic [NUM_PARALLEL_INSTANCES*32-1:0]             grant_count,
  output logic [31:0]                                      out_stall_count
);

  localparam int N = NUM_PARALLEL_INSTANCES;
  localparam int D = MAX_DEPENDENCIES;

  // Handshake: a beat moves on an edge where valid and ready are both high. Valid never
  // waits for ready; the output holds data steady from valid until ready is sampled high.
  // Input ready is raised only for the arbitration winner and only when the output
  // register is empty or draining in the same cycle.
  logic                  load;
  logic                  accept;
  logic [N-1:0]          grant;
  logic [SRC_W-1:0]      grant_idx;
  logic [OWNER_ID_W-1:0] sel_owner;
  logic [D-1:0]          sel_rd;
  logic [D-1:0]          sel_wr;

  assign load          = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = grant;
  assign accept        = |(grant & s_axis_tvalid);

  rr_arbiter #(.N(N), .IW(SRC_W)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (s_axis_tvalid),
    .enable    (load && !rst),
    .accept    (accept),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_comb begin
    sel_owner = s_axis_tdata_owner_programID[int'(grant_idx)*OWNER_ID_W +: OWNER_ID_W];
    sel_rd    = s_axis_tdata_read_dependencies[int'(grant_idx)*D +: D];
    sel_wr    = s_axis_tdata_write_dependencies[int'(grant_idx)*D +: D];
  end

  // Data registers only load on an accepted beat; an idle load just drops valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_axis_tvalid                   <= 1'b0;
      m_axis_tdest                    <= '0;
      m_axis_tdata_owner_programID    <= '0;
      m_axis_tdata_read_dependencies  <= '0;
      m_axis_tdata_write_dependencies <= '0;
    end else if (load) begin
      m_axis_tvalid <= accept;
      if (accept) begin
        m_axis_tdest                    <= grant_idx;
        m_axis_tdata_owner_programID    <= sel_owner;
        m_axis_tdata_read_dependencies  <= sel_rd;
        m_axis_tdata_write_dependencies <= sel_wr;
      end
    end
  end

`ifdef ARB_STATS_EN
  logic [31:0] gcnt [N];
  logic [31:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) gcnt[i] <= '0;
      stall_cnt <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (grant[i] && s_axis_tvalid[i]) gcnt[i] <= gcnt[i] + 32'd1;
      end
      if (m_axis_tvalid && !m_axis_tready) stall_cnt <= stall_cnt + 32'd1;
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_cnt
    assign grant_count[g*32 +: 32] = gcnt[g];
  end
  assign out_stall_count = stall_cnt;
`else
  assign grant_count     = '0;
  assign out_stall_count = '0;
`endif

endmodule

// File: tb/tb_batch_output_arbiter.sv
// Directed bench for batch_output_arbiter: reset, round-robin order, single-source burst,
// priority rotation, backpressure, randomized traffic and mid-operation reset.
module tb_batch_output_arbiter;

  localparam int N  = 4;
  localparam int D  = 256;
  localparam int SW = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]    s_vld, s_rdy;
  logic [N*64-1:0] s_own;
  logic [N*D-1:0]  s_rd, s_wr;
  logic            m_vld, m_rdy;
  logic [63:0]     m_own;
  logic [D-1:0]    m_rd, m_wr;
  logic [SW-1:0]   m_dest;
  logic [N*32-1:0] gcnt;
  logic [31:0]     stall_cnt;

  logic [63:0] s_id [N];

  batch_output_arbiter #(
    .NUM_PARALLEL_INSTANCES (N),
    .MAX_DEPENDENCIES       (D)
  ) dut (
    .clk                             (clk),
    .rst                             (rst),
    .s_axis_tvalid                   (s_vld),
    .s_axis_tready                   (s_rdy),
    .s_axis_tdata_owner_programID    (s_own),
    .s_axis_tdata_read_dependencies  (s_rd),
    .s_axis_tdata_write_dependencies (s_wr),
    .m_axis_tvalid                   (m_vld),
    .m_axis_tready                   (m_rdy),
    .m_axis_tdata_owner_programID    (m_own),
    .m_axis_tdata_read_dependencies  (m_rd),
    .m_axis_tdata_write_dependencies (m_wr),
    .m_axis_tdest                    (m_dest),
    .grant_count                     (gcnt),
    .out_stall_count                 (stall_cnt)
  );

  function automatic logic [D-1:0] rd_pat(input logic [63:0] id);
    return {4{id}};
  endfunction

  function automatic logic [D-1:0] wr_pat(input logic [63:0] id);
    return {4{~id}};
  endfunction

  // Instance i's k-th beat carries owner ID 10*(k+1)+i.
  function automatic logic [63:0] id_of(input int i, input int seq);
    return 64'(10 * (seq + 1) + i);
  endfunction

  always_comb begin
    for (int i = 0; i < N; i++) begin
      s_own[i*64 +: 64] = s_id[i];
      s_rd[i*D +: D]    = rd_pat(s_id[i]);
      s_wr[i*D +: D]    = wr_pat(s_id[i]);
    end
  end

  // scoreboard state
  int tests = 0;
  int fails = 0;
  int in_seq [N];
  int out_seq [N];
  int lim [N];
  logic [N-1:0] en;
  bit rnd_mode;
  logic [63:0] exp_q[$];
  int cyc, out_first, out_last, out_n, acc_total, out_total;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic refresh();
    for (int i = 0; i < N; i++) begin
      if (rnd_mode) begin
        if (!s_vld[i]) s_vld[i] = 1'($urandom_range(0, 1));
      end else begin
        s_vld[i] = en[i] && (in_seq[i] < lim[i]);
      end
      s_id[i] = id_of(i, in_seq[i]);
    end
  endtask

  task automatic check_out();
    int d;
    logic [63:0] e;
    d = int'(m_dest);
    e = id_of(d, out_seq[d]);
    chk("out_owner", m_own, e);
    chk("out_rd", m_rd, rd_pat(e));
    chk("out_wr", m_wr, wr_pat(e));
    if (exp_q.size() > 0) chk("out_order", m_own, exp_q.pop_front());
    out_seq[d]++;
    out_total++;
    if (out_n == 0) out_first = cyc;
    out_last = cyc;
    out_n++;
  endtask

  task automatic step();
    logic [N-1:0] hs;
    @(negedge clk);
    chk("rdy_onehot0", $onehot0(s_rdy), 1'b1);
    if (m_vld && !m_rdy) chk("rdy_when_full", s_rdy, 0);
    if (m_vld && m_rdy) check_out();
    hs = s_vld & s_rdy;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (hs[i]) begin
        in_seq[i]++;
        acc_total++;
        if (rnd_mode) s_vld[i] = 1'b0;
      end
    end
    refresh();
  endtask

  task automatic drain(input string tag, input int budget);
    for (int k = 0; k < budget && exp_q.size() > 0; k++) step();
    chk({tag, "_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sum;
    rst = 1'b1;
    m_rdy = 1'b0;
    rnd_mode = 1'b0;
    s_vld = '0;
    for (int i = 0; i < N; i++) lim[i] = 1;
    en = 4'b1111;
    refresh();

    // Reset: ready held low even with every input valid.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rdy", s_rdy, 0);
    chk("rst_vld", m_vld, 0);
    @(posedge clk);
    #1;
    en = '0;
    refresh();
    rst = 1'b0;
    #2;
    chk("idle_vld", m_vld, 0);
    chk("idle_rdy", s_rdy, 0);
    chk("idle_dest", m_dest, 0);
    chk("idle_own", m_own, 0);
    chk("idle_gcnt", gcnt, 0);
    chk("idle_stall", stall_cnt, 0);
    step();
    step();
    chk("idle_vld2", m_vld, 0);

    // Round robin over all four instances, two beats each, no bubbles.
    m_rdy = 1'b1;
    en = 4'b1111;
    for (int i = 0; i < N; i++) lim[i] = 2;
    exp_q = '{64'd10, 64'd11, 64'd12, 64'd13, 64'd20, 64'd21, 64'd22, 64'd23};
    out_n = 0;
    refresh();
    drain("rr", 20);
    chk("rr_count", out_n, 8);
    chk("rr_burst", out_last - out_first + 1, 8);
    chk("rr_idle", m_vld, 0);

    // Single instance back-to-back.
    en = 4'b0100;
    lim[2] = 7;
    exp_q = '{64'd32, 64'd42, 64'd52, 64'd62, 64'd72};
    out_n = 0;
    refresh();
    drain("solo", 15);
    chk("solo_count", out_n, 5);
    chk("solo_burst", out_last - out_first + 1, 5);

    // last_grant=2, so instance 3 wins, then 0, then 1.
    en = 4'b1011;
    lim[0] = 3; lim[1] = 3; lim[3] = 3;
    exp_q = '{64'd33, 64'd30, 64'd31};
    out_n = 0;
    refresh();
    drain("prio", 10);

    // Backpressure: one beat held for 7 stalled cycles, then resume.
    en = 4'b1111;
    lim[0] = 6; lim[1] = 6; lim[2] = 10; lim[3] = 6;
    m_rdy = 1'b0;
    exp_q = '{64'd82, 64'd43, 64'd40, 64'd41, 64'd92, 64'd53,
              64'd50, 64'd51, 64'd102, 64'd63, 64'd60, 64'd61};
    out_n = 0;
    refresh();
    step();
    repeat (7) begin
      step();
      chk("stall_vld", m_vld, 1);
      chk("stall_data", m_own, 82);
    end
`ifdef ARB_STATS_EN
    chk("stall_cnt", stall_cnt, 7);
`else
    chk("stall_cnt", stall_cnt, 0);
`endif
    m_rdy = 1'b1;
    drain("stall_rel", 30);
    chk("stall_rel_count", out_n, 12);
    chk("stall_rel_burst", out_last - out_first + 1, 12);
    for (int i = 0; i < N; i++) begin
`ifdef ARB_STATS_EN
      chk("gcnt_dir", gcnt[i*32 +: 32], in_seq[i]);
`else
      chk("gcnt_dir", gcnt[i*32 +: 32], 0);
`endif
    end

    // Random valid/ready traffic; per-instance ordering checked on every output.
    rnd_mode = 1'b1;
    s_vld = '0;
    refresh();
    for (int k = 0; k < 10000; k++) begin
      m_rdy = ($urandom_range(0, 3) != 0);
      step();
    end
    chk("rand_conserve", acc_total, out_total + int'(m_vld));
    sum = 0;
    for (int i = 0; i < N; i++) sum += int'(gcnt[i*32 +: 32]);
`ifdef ARB_STATS_EN
    chk("rand_gcnt_sum", sum, acc_total);
`else
    chk("rand_gcnt_sum", sum, 0);
`endif

    // Reset while a beat is held: beat discarded, instance 0 first afterwards.
    rnd_mode = 1'b0;
    en = '0;
    m_rdy = 1'b1;
    refresh();
    for (int k = 0; k < 5 && m_vld; k++) step();
    chk("pre_rst_empty", m_vld, 0);
    m_rdy = 1'b0;
    en = 4'b1000;
    lim[3] = in_seq[3] + 1;
    refresh();
    step();
    chk("hold_vld", m_vld, 1);
    chk("hold_dest", m_dest, 3);
    step();
    en = 4'b1111;
    for (int i = 0; i < N; i++) lim[i] = in_seq[i] + 1;
    refresh();
    rst = 1'b1;
    step();
    chk("mid_rst_vld", m_vld, 0);
    chk("mid_rst_dest", m_dest, 0);
    chk("mid_rst_own", m_own, 0);
    chk("mid_rst_rd", m_rd, 0);
    chk("mid_rst_gcnt", gcnt, 0);
    chk("mid_rst_stall", stall_cnt, 0);
    rst = 1'b0;
    for (int i = 0; i < N; i++) out_seq[i] = in_seq[i];
    m_rdy = 1'b1;
    for (int i = 0; i < N; i++) exp_q.push_back(id_of(i, in_seq[i]));
    out_n = 0;
    refresh();
    drain("post_rst", 10);
    chk("post_rst_count", out_n, 4);

    // final report
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
